// File: rtl/arbiter_pkg.sv
// Shared constants and helpers for the request arbiter: legal parameter strings,
// FSM state encoding and the encoded-index width function.
package arbiter_pkg;

  localparam string TYPE_PRIORITY     = "PRIORITY";
  localparam string TYPE_ROUND_ROBIN  = "ROUND_ROBIN";
  localparam string BLOCK_NONE        = "NONE";
  localparam string BLOCK_REQUEST     = "REQUEST";
  localparam string BLOCK_ACKNOWLEDGE = "ACKNOWLEDGE";
  localparam string LSB_LOW           = "LOW";
  localparam string LSB_HIGH          = "HIGH";

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANTED
  } arb_state_e;

  function automatic int encWidth(input int ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

endpackage

// File: rtl/priority_encoder.sv
// Combinational priority encoder: reports whether any input is set and the index
// of the winning bit, with index 0 or index WIDTH-1 as the highest priority.
module priority_encoder
  import arbiter_pkg::*;
#(
  parameter int    WIDTH        = 4,
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic [WIDTH-1:0]           req_i,
  output logic                       valid_o,
  output logic [encWidth(WIDTH)-1:0] index_o
);

  localparam int EW         = encWidth(WIDTH);
  localparam bit HIGH_FIRST = (LSB_PRIORITY == LSB_HIGH);

  if (!(LSB_PRIORITY == LSB_LOW || LSB_PRIORITY == LSB_HIGH)) begin : gBadLsb
    $error("priority_encoder: illegal LSB_PRIORITY %s", LSB_PRIORITY);
  end

  // The scan runs towards the preferred end so the last hit is the winner.
  always_comb begin
    index_o = '0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (req_i[i]) index_o = EW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (req_i[i]) index_o = EW'(i);
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/req_arbiter.sv
// Registered N-port request arbiter with fixed or round-robin selection and an
// optional hold (block) mode released by request drop or acknowledge.
module req_arbiter
  import arbiter_pkg::*;
#(
  parameter int    PORTS        = 4,
  parameter string TYPE         = "PRIORITY",
  parameter string BLOCK        = "NONE",
  parameter string LSB_PRIORITY = "LOW"
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [PORTS-1:0]           request,
  input  logic [PORTS-1:0]           acknowledge,
  output logic [PORTS-1:0]           grant,
  output logic                       grant_valid,
  output logic [encWidth(PORTS)-1:0] grant_encoded
);

  localparam int EW         = encWidth(PORTS);
  localparam bit IS_RR      = (TYPE == TYPE_ROUND_ROBIN);
  localparam bit HIGH_FIRST = (LSB_PRIORITY == LSB_HIGH);
  localparam bit BLK_REQ    = (BLOCK == BLOCK_REQUEST);
  localparam bit BLK_ACK    = (BLOCK == BLOCK_ACKNOWLEDGE);

  if (PORTS < 2) begin : gBadPorts
    $error("req_arbiter: PORTS must be at least 2");
  end
  if (!(TYPE == TYPE_PRIORITY || TYPE == TYPE_ROUND_ROBIN)) begin : gBadType
    $error("req_arbiter: illegal TYPE %s", TYPE);
  end
  if (!(BLOCK == BLOCK_NONE || BLK_REQ || BLK_ACK)) begin : gBadBlock
    $error("req_arbiter: illegal BLOCK %s", BLOCK);
  end

  arb_state_e       state_q, state_d;
  logic [PORTS-1:0] grantVec_q, grantVec_d;
  logic [PORTS-1:0] mask_q, mask_d;
  logic [EW-1:0]    index_q, index_d;

  logic          plainValid, maskedValid, releaseGrant;
  logic [EW-1:0] plainIndex, maskedIndex, winnerIndex;

  priority_encoder #(.WIDTH(PORTS), .LSB_PRIORITY(LSB_PRIORITY)) plainEnc (
    .req_i   (request),
    .valid_o (plainValid),
    .index_o (plainIndex)
  );

  if (IS_RR) begin : gRr
    priority_encoder #(.WIDTH(PORTS), .LSB_PRIORITY(LSB_PRIORITY)) maskedEnc (
      .req_i   (request & mask_q),
      .valid_o (maskedValid),
      .index_o (maskedIndex)
    );
  end else begin : gFixed
    assign maskedValid = 1'b0;
    assign maskedIndex = '0;
  end

  assign winnerIndex = (IS_RR && maskedValid) ? maskedIndex : plainIndex;

  always_comb begin
    releaseGrant = 1'b1;
    if (BLK_REQ)      releaseGrant = ~request[index_q];
    else if (BLK_ACK) releaseGrant = acknowledge[index_q];
  end

  // The mask keeps only the ports that come after the new winner in rotation order.
  always_comb begin
    state_d    = state_q;
    grantVec_d = grantVec_q;
    index_d    = index_q;
    mask_d     = mask_q;
    if (state_q == ARB_IDLE || releaseGrant) begin
      if (plainValid) begin
        state_d                 = ARB_GRANTED;
        index_d                 = winnerIndex;
        grantVec_d              = '0;
        grantVec_d[winnerIndex] = 1'b1;
        for (int i = 0; i < PORTS; i++) begin
          mask_d[i] = HIGH_FIRST ? (i < int'(winnerIndex)) : (i > int'(winnerIndex));
        end
      end else begin
        state_d    = ARB_IDLE;
        grantVec_d = '0;
        index_d    = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grantVec_q <= '0;
      index_q    <= '0;
      mask_q     <= '1;
    end else begin
      state_q    <= state_d;
      grantVec_q <= grantVec_d;
      index_q    <= index_d;
      mask_q     <= mask_d;
    end
  end

  assign grant         = grantVec_q;
  assign grant_valid   = (state_q == ARB_GRANTED);
  assign grant_encoded = index_q;

endmodule

// File: tb/tb_req_arbiter.sv
// Self-checking bench for req_arbiter: six configurations share one stimulus stream,
// directed scenarios check fixed expectations and a random run checks a reference model.
module tb_req_arbiter;

  localparam int P    = 4;
  localparam int NDUT = 6;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [P-1:0] request = '0;
  logic [P-1:0] acknowledge = '0;

  logic [P-1:0] gnt [NDUT];
  logic         gv  [NDUT];
  logic [1:0]   ge  [NDUT];

  int checks = 0;
  int errors = 0;

  // Configuration table: round robin flag, block mode (0 none, 1 request, 2 ack), high-first flag
  bit cfgRr   [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  int cfgBlk  [NDUT] = '{0, 0, 0, 1, 2, 0};
  bit cfgHigh [NDUT] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

  // Reference model state: whether a grant is held, its index, and the last port granted
  bit mValid [NDUT];
  int mIdx   [NDUT];
  int mLast  [NDUT];

  // Free-running clock with a 10-unit period
  always #5 clk = ~clk;

  req_arbiter #(.PORTS(P), .TYPE("PRIORITY"), .BLOCK("NONE"), .LSB_PRIORITY("LOW")) dut0 (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[0]), .grant_valid(gv[0]), .grant_encoded(ge[0]));
  req_arbiter #(.PORTS(P), .TYPE("PRIORITY"), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) dut1 (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[1]), .grant_valid(gv[1]), .grant_encoded(ge[1]));
  req_arbiter #(.PORTS(P), .TYPE("ROUND_ROBIN"), .BLOCK("NONE"), .LSB_PRIORITY("LOW")) dut2 (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[2]), .grant_valid(gv[2]), .grant_encoded(ge[2]));
  req_arbiter #(.PORTS(P), .TYPE("ROUND_ROBIN"), .BLOCK("REQUEST"), .LSB_PRIORITY("LOW")) dut3 (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[3]), .grant_valid(gv[3]), .grant_encoded(ge[3]));
  req_arbiter #(.PORTS(P), .TYPE("ROUND_ROBIN"), .BLOCK("ACKNOWLEDGE"), .LSB_PRIORITY("LOW")) dut4 (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[4]), .grant_valid(gv[4]), .grant_encoded(ge[4]));
  req_arbiter #(.PORTS(P), .TYPE("ROUND_ROBIN"), .BLOCK("NONE"), .LSB_PRIORITY("HIGH")) dut5 (
    .clk(clk), .rst(rst), .request(request), .acknowledge(acknowledge),
    .grant(gnt[5]), .grant_valid(gv[5]), .grant_encoded(ge[5]));

  // Round robin is a circular search starting just past the last grant;
  // fixed priority is a straight scan from the preferred end.
  function automatic void modelStep(input logic r, input logic [P-1:0] req, input logic [P-1:0] ack);
    for (int k = 0; k < NDUT; k++) begin
      bit rel;
      int w;
      int c;
      if (r) begin
        mValid[k] = 1'b0;
        mIdx[k]   = 0;
        mLast[k]  = cfgHigh[k] ? 0 : P - 1;
        continue;
      end
      rel = !mValid[k] || cfgBlk[k] == 0 ||
            (cfgBlk[k] == 1 && !req[mIdx[k]]) || (cfgBlk[k] == 2 && ack[mIdx[k]]);
      if (!rel) continue;
      if (req == '0) begin
        mValid[k] = 1'b0;
        mIdx[k]   = 0;
        continue;
      end
      w = -1;
      for (int s = 1; s <= P; s++) begin
        if (cfgRr[k]) c = cfgHigh[k] ? (mLast[k] - s + P) % P : (mLast[k] + s) % P;
        else          c = cfgHigh[k] ? P - s : s - 1;
        if (w < 0 && req[c]) w = c;
      end
      mValid[k] = 1'b1;
      mIdx[k]   = w;
      mLast[k]  = w;
    end
  endfunction

  task automatic applyStimulus(input logic r, input logic [P-1:0] req, input logic [P-1:0] ack);
    rst         = r;
    request     = req;
    acknowledge = ack;
    @(posedge clk);
    modelStep(r, req, ack);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b1, 4'b1111, 4'b0000);
      for (int k = 0; k < NDUT; k++) begin
        checks++;
        if ({gv[k], ge[k], gnt[k]} !== 7'b0) begin
          errors++;
          $display("[TB] FAIL reset dut%0d cycle%0d: got v/enc/grant=%b want 0000000", k, c, {gv[k], ge[k], gnt[k]});
        end
      end
    end
  endtask

  task automatic test_fixed_priority();
    logic [P-1:0] reqs [2] = '{4'b0110, 4'b1010};
    logic [6:0]   exp0 [2] = '{7'b1_01_0010, 7'b1_01_0010};
    logic [6:0]   exp1 [2] = '{7'b1_10_0100, 7'b1_11_1000};
    for (int c = 0; c < 2; c++) begin
      applyStimulus(1'b0, reqs[c], 4'b0000);
      checks++;
      if ({gv[0], ge[0], gnt[0]} !== exp0[c]) begin
        errors++;
        $display("[TB] FAIL fixed_low step%0d: got %b want %b", c, {gv[0], ge[0], gnt[0]}, exp0[c]);
      end
      checks++;
      if ({gv[1], ge[1], gnt[1]} !== exp1[c]) begin
        errors++;
        $display("[TB] FAIL fixed_high step%0d: got %b want %b", c, {gv[1], ge[1], gnt[1]}, exp1[c]);
      end
    end
  endtask

  task automatic test_round_robin();
    int expLow  [10] = '{0, 1, 2, 3, 0, 1, 3, 0, 3, 0};
    int expHigh [10] = '{3, 2, 1, 0, 3, 2, 0, 3, 0, 3};
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0, (c < 6) ? 4'b1111 : 4'b1001, 4'b0000);
      checks++;
      if ({gv[2], ge[2], gnt[2]} !== {1'b1, 2'(expLow[c]), 4'(1 << expLow[c])}) begin
        errors++;
        $display("[TB] FAIL rr_low step%0d: got v=%b enc=%0d grant=%b want enc=%0d", c, gv[2], ge[2], gnt[2], expLow[c]);
      end
      checks++;
      if ({gv[5], ge[5], gnt[5]} !== {1'b1, 2'(expHigh[c]), 4'(1 << expHigh[c])}) begin
        errors++;
        $display("[TB] FAIL rr_high step%0d: got v=%b enc=%0d grant=%b want enc=%0d", c, gv[5], ge[5], gnt[5], expHigh[c]);
      end
    end
  endtask

  task automatic test_request_block();
    logic [P-1:0] reqs [5] = '{4'b0011, 4'b0011, 4'b0011, 4'b0010, 4'b0000};
    logic [6:0]   exps [5] = '{7'b1_00_0001, 7'b1_00_0001, 7'b1_00_0001, 7'b1_01_0010, 7'b0};
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      applyStimulus(1'b0, reqs[c], 4'b0000);
      checks++;
      if ({gv[3], ge[3], gnt[3]} !== exps[c]) begin
        errors++;
        $display("[TB] FAIL request_block step%0d: got %b want %b", c, {gv[3], ge[3], gnt[3]}, exps[c]);
      end
    end
  endtask

  task automatic test_ack_block();
    logic [P-1:0] reqs [7] = '{4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0100};
    logic [P-1:0] acks [7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100, 4'b0001, 4'b0000};
    logic [6:0]   exps [7] = '{7'b1_00_0001, 7'b1_00_0001, 7'b1_00_0001, 7'b1_00_0001,
                               7'b1_00_0001, 7'b1_10_0100, 7'b1_10_0100};
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 7; c++) begin
      applyStimulus(1'b0, reqs[c], acks[c]);
      checks++;
      if ({gv[4], ge[4], gnt[4]} !== exps[c]) begin
        errors++;
        $display("[TB] FAIL ack_block step%0d: got %b want %b", c, {gv[4], ge[4], gnt[4]}, exps[c]);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    logic       rsts [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [P-1:0] reqs [4] = '{4'b0100, 4'b0100, 4'b0100, 4'b1111};
    logic [6:0] exps [4] = '{7'b1_10_0100, 7'b1_10_0100, 7'b0, 7'b1_00_0001};
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 4; c++) begin
      applyStimulus(rsts[c], reqs[c], 4'b0000);
      checks++;
      if ({gv[3], ge[3], gnt[3]} !== exps[c]) begin
        errors++;
        $display("[TB] FAIL reset_mid_grant step%0d: got %b want %b", c, {gv[3], ge[3], gnt[3]}, exps[c]);
      end
    end
  endtask

  task automatic test_random();
    logic         r;
    logic [P-1:0] req, ack, expG;
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    for (int c = 0; c < 400; c++) begin
      r   = ($urandom_range(0, 49) == 0);
      req = 4'($urandom);
      if ($urandom_range(0, 2) == 0) req = req & 4'($urandom);
      ack = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
      applyStimulus(r, req, ack);
      for (int k = 0; k < NDUT; k++) begin
        expG = mValid[k] ? 4'(1 << mIdx[k]) : 4'b0000;
        checks++;
        if ({gv[k], ge[k], gnt[k]} !== {mValid[k], 2'(mIdx[k]), expG}) begin
          errors++;
          $display("[TB] FAIL random dut%0d cycle%0d: got %b want %b", k, c,
                   {gv[k], ge[k], gnt[k]}, {mValid[k], 2'(mIdx[k]), expG});
        end
      end
    end
  endtask

  // Scenario sequence; each task leaves the bench in a known state for the next
  initial begin
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_request_block();
    test_ack_block();
    test_reset_mid_grant();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_arbiter.md
# req_arbiter

Registered N-port request arbiter that shares one downstream resource (a mux, bus, or output port) between requesters. Selection uses the existing `priority_encoder`: fixed priority, or round-robin via a masked second encoder. An optional block mode holds the grant until the request drops or the requester acknowledges. It sits between requesters and the resource's select/mux logic and drives the select index directly.

## Interface
- `PORTS`, default 4: number of requesters, ≥ 2.
- `TYPE`, default "PRIORITY": "PRIORITY" (fixed) or "ROUND_ROBIN".
- `BLOCK`, default "NONE": "NONE" (re-arbitrate every cycle), "REQUEST" (hold while the request stays high) or "ACKNOWLEDGE" (hold until acknowledged).
- `LSB_PRIORITY`, default "LOW": "LOW" means index 0 wins; "HIGH" means index PORTS-1 wins.

Ports:
- `clk`  in  1: clock. One clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `request`  in  PORTS: per-port request, level-sensitive.
- `acknowledge`  in  PORTS: per-port release strobe. Used only when BLOCK="ACKNOWLEDGE".
- `grant`  out  PORTS: one-hot grant, registered.
- `grant_valid`  out  1: a grant is held, registered.
- `grant_encoded`  out  $clog2(PORTS): binary index of `grant`, registered.

## Operation
- States:
  - IDLE: `grant_valid`=0, `grant`=0, `grant_encoded`=0.
  - GRANTED: exactly one `grant` bit set, `grant_encoded` equals its index, `grant_valid`=1.
- Release condition, evaluated each cycle while GRANTED:
  - NONE: always released.
  - REQUEST: released when `request[grant_encoded]`=0.
  - ACKNOWLEDGE: released when `acknowledge[grant_encoded]`=1. The request level is ignored while the grant is held.
- Not released: all outputs hold their values and the round-robin mask is unchanged.
- IDLE or released: arbitrate over the current `request` vector.
  - If any request is set, register the winner and go to (or stay in) GRANTED.
  - If no request is set, go to IDLE and clear the outputs.
- Fixed priority: the winner is the `priority_encoder` result on `request`, honouring `LSB_PRIORITY`.
- Round robin:
  - A mask register excludes the last granted index and all indices ahead of it in priority order.
    - LOW: keep indices > last.
    - HIGH: keep indices < last.
  - If `request & mask` ≠ 0, the winner comes from the masked encoder; otherwise from the unmasked encoder.
  - The mask is updated only when a new grant is registered. It is all-ones after reset.
- `acknowledge` on a non-granted port, or while IDLE, is ignored.
- A granted port whose request is still set at release may win again.
  - Fixed priority: it wins again if it is still the highest-priority request.
  - Round robin: it wins again only if no other port is requesting.

## Timing
- Reset values: `grant`=0, `grant_valid`=0, `grant_encoded`=0, RR mask all-ones. `rst` takes effect on the next `clk` edge, including mid-grant; there is no partial release.
- Latency: `request` sampled at edge N gives `grant` valid after edge N (one cycle). There is no combinational path from inputs to outputs.
- Release and re-grant happen at the same edge, so there is no idle cycle between back-to-back grants.
- Grant change in ACKNOWLEDGE mode: `acknowledge` high at edge N means the new grant (or IDLE) is visible after edge N.
- Round robin with all PORTS requests held continuously: each port is granted once every PORTS cycles in BLOCK=NONE.
- All inputs are sampled only at the `clk` edge.

## Structure
- Shared package `arbiter_pkg`:
  - string constants for `TYPE`, `BLOCK` and `LSB_PRIORITY` values;
  - a function for the encoded width, `$clog2(PORTS)`.
- Sub-module: reuse `priority_encoder` (WIDTH=PORTS, LSB_PRIORITY passed through).
  - Two instances: one on `request`, one on `request & mask`.
  - Only the unmasked instance is needed for TYPE="PRIORITY".
- Keep the grant, mask and state registers in one always block, with combinational next-state logic separate.
- Illegal parameter strings fail at elaboration.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with `request`=4'b1111 -> `grant`=0, `grant_valid`=0, `grant_encoded`=0 throughout.
- Fixed priority, NONE, LOW: `request`=4'b0110 -> next cycle `grant`=4'b0010, `grant_encoded`=1. With LSB_PRIORITY=HIGH -> `grant`=4'b0100, `grant_encoded`=2.
- Round robin, NONE: `request`=4'b1111 held for 6 cycles -> `grant_encoded` sequence 0,1,2,3,0,1. Then `request`=4'b1001 -> the port after the last grant in rotation wins, and the two ports alternate.
- REQUEST block, round robin: `request`=4'b0011 -> grant 0 held while `request[0]`=1. Drop `request[0]` -> next cycle grant 1 with no idle gap. Drop all -> `grant_valid`=0.
- ACKNOWLEDGE block: `request`=4'b0101 -> grant 0.
  - `request`=0 for 3 cycles -> grant 0 still held.
  - `acknowledge`=4'b0100 -> ignored.
  - `acknowledge`=4'b0001 with `request`=4'b0100 -> next cycle grant 2.
- Reset mid-grant, round robin: grant 2 held, assert `rst` -> outputs 0 after the edge. Release `rst` with `request`=4'b1111 -> grant 0, confirming the mask was reset.
